io_unit: RTL and testbench

IO_UNIT -- requirements
Module: io_unit

---
 rtl/io_unit.sv | 178 +++++++++++++++++
 tb/tb_io_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_unit.sv
// I/O unit for the basic computer: input/output flags, device handshakes, skip and interrupt request.
// Build option: define IO_RX_FIFO_EN to place a 4-entry receive FIFO between the input device and inpr.
//
// Output path state | meaning
// OUT_IDLE          | fgo=1, no byte offered to the output device
// OUT_BUSY          | fgo=0, dev_out_valid=1, dev_out_data held until dev_out_ready
module io_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        io_exec,
  input  logic        int_ack,
  input  logic [7:0]  ac_low,
  output logic [7:0]  inpr,
  input  logic [7:0]  dev_in_data,
  input  logic        dev_in_valid,
  output logic        dev_in_ready,
  output logic [7:0]  dev_out_data,
  output logic        dev_out_valid,
  input  logic        dev_out_ready,
  output logic        skip,
  output logic        fgi,
  output logic        fgo,
  output logic        ien,
  output logic        irq,
  output logic        out_err
);

  typedef enum logic {OUT_IDLE, OUT_BUSY} out_state_e;

  out_state_e  out_state_q;
  logic        fgo_q;
  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        out_err_q;

  logic        inp_cmd;
  logic        out_cmd;
  logic        ion_cmd;
  logic        iof_cmd;
  logic        unused_ir;

  logic        fgi_q, fgi_d;
  logic [7:0]  inpr_q, inpr_d;
  logic        ien_q, ien_d;
  logic        irq_q, irq_d;

  assign inp_cmd   = io_exec & ir[11];
  assign out_cmd   = io_exec & ir[10];
  assign ion_cmd   = io_exec & ir[7];
  assign iof_cmd   = io_exec & ir[6];
  assign unused_ir = ^{ir[15:12], ir[5:0]};

  assign skip = io_exec & ((ir[9] & fgi_q) | (ir[8] & fgo_q));

`ifdef IO_RX_FIFO_EN
  logic [7:0] rx_mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       push;
  logic       pop;

  assign dev_in_ready = (count_q != 3'd4);
  assign push         = dev_in_valid & dev_in_ready;
  // The head only moves once the CPU has consumed the previous byte.
  assign pop          = ~fgi_q & (count_q != 3'd0);

  always_comb begin
    fgi_d  = fgi_q;
    inpr_d = inpr_q;
    if (inp_cmd) fgi_d = 1'b0;
    if (pop) begin
      fgi_d  = 1'b1;
      inpr_d = rx_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rx_mem_q[i] <= 8'h00;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) begin
        rx_mem_q[wr_ptr_q] <= dev_in_data;
        wr_ptr_q           <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end
`else
  logic in_accept;

  // While fgi is set the device is held off, so an INP never races a new byte.
  assign dev_in_ready = ~fgi_q;
  assign in_accept    = dev_in_valid & ~fgi_q;

  always_comb begin
    fgi_d  = fgi_q;
    inpr_d = inpr_q;
    if (inp_cmd) fgi_d = 1'b0;
    if (in_accept) begin
      fgi_d  = 1'b1;
      inpr_d = dev_in_data;
    end
  end
`endif

  always_comb begin
    ien_d = ien_q;
    if (ion_cmd) ien_d = 1'b1;
    if (iof_cmd) ien_d = 1'b0;
    if (int_ack) ien_d = 1'b0;
  end

  assign irq_d = int_ack ? 1'b0 : (ien_q & (fgi_q | fgo_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fgi_q  <= 1'b0;
      inpr_q <= 8'h00;
      ien_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      fgi_q  <= fgi_d;
      inpr_q <= inpr_d;
      ien_q  <= ien_d;
      irq_q  <= irq_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_state_q <= OUT_IDLE;
      fgo_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_err_q   <= 1'b0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (out_cmd) begin
            out_data_q  <= ac_low;
            out_state_q <= OUT_BUSY;
            fgo_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        OUT_BUSY: begin
          if (out_cmd) out_err_q <= 1'b1;
          if (dev_out_ready) begin
            out_state_q <= OUT_IDLE;
            fgo_q       <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_state_q <= OUT_IDLE;
          fgo_q       <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign inpr          = inpr_q;
  assign fgi           = fgi_q;
  assign fgo           = fgo_q;
  assign ien           = ien_q;
  assign irq           = irq_q;
  assign out_err       = out_err_q;
  assign dev_out_data  = out_data_q;
  assign dev_out_valid = out_valid_q;

endmodule

// File: tb/tb_io_unit.sv
// Bench for io_unit: directed scenarios, then random traffic against a flag-level model with
// data scoreboards for the input and output byte streams.
module tb_io_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        io_exec;
  logic        int_ack;
  logic [7:0]  ac_low;
  logic [7:0]  inpr;
  logic [7:0]  dev_in_data;
  logic        dev_in_valid;
  logic        dev_in_ready;
  logic [7:0]  dev_out_data;
  logic        dev_out_valid;
  logic        dev_out_ready;
  logic        skip;
  logic        fgi, fgo, ien, irq, out_err;

  io_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .io_exec(io_exec), .int_ack(int_ack), .ac_low(ac_low),
    .inpr(inpr), .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid),
    .dev_in_ready(dev_in_ready), .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid),
    .dev_out_ready(dev_out_ready), .skip(skip), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_in[$];
  logic [7:0] exp_out[$];
  logic       sb_on = 1'b0;
  logic       fgi_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, e);
    end
  endtask

  task automatic chk_empty_pop(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT produced a byte but none was expected", name);
  endtask

  // Scoreboard monitor: sampled mid-low-phase, after stimulus has settled.
  always begin
    @(negedge clk);
    #2;
    if (sb_on) begin
      if (fgi && !fgi_prev) begin
        if (exp_in.size() == 0) chk_empty_pop("inpr_stream");
        else chk("inpr_stream", inpr, exp_in.pop_front());
      end
      if (dev_out_valid && dev_out_ready) begin
        if (exp_out.size() == 0) chk_empty_pop("out_stream");
        else chk("out_stream", dev_out_data, exp_out.pop_front());
      end
    end
    fgi_prev = fgi;
  end

  // Random-phase model state
  logic       fgi_m, out_pend, err_m, ien_m, irq_m, in_busy;
  logic [7:0] in_byte;
  int         fifo_cnt;

  initial begin
    logic ready_m, acc, pop, inp_c, out_c, ion_c, iof_c, skip_e;
    logic fgi_n, pend_n, ien_n, irq_n;

    rst = 1'b1; ir = 16'h0; io_exec = 1'b0; int_ack = 1'b0; ac_low = 8'h0;
    dev_in_data = 8'h0; dev_in_valid = 1'b0; dev_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inpr", inpr, 8'h00);
    chk("rst_fgi", fgi, 1'b0);
    chk("rst_fgo", fgo, 1'b1);
    chk("rst_ien", ien, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_valid", dev_out_valid, 1'b0);
    chk("rst_data", dev_out_data, 8'h00);
    chk("rst_in_ready", dev_in_ready, 1'b1);

    // Input transfer and SKI
    dev_in_data = 8'hA5; dev_in_valid = 1'b1;
    @(negedge clk);
    dev_in_valid = 1'b0;
`ifdef IO_RX_FIFO_EN
    @(negedge clk);
    chk("in_ready_after_xfer", dev_in_ready, 1'b1);
`else
    chk("in_ready_after_xfer", dev_in_ready, 1'b0);
`endif
    chk("inpr_a5", inpr, 8'hA5);
    chk("fgi_set", fgi, 1'b1);
    io_exec = 1'b1; ir = 16'h0200;
    #1 chk("ski_skip", skip, 1'b1);
    ir = 16'h0800;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0;
    chk("inp_clears_fgi", fgi, 1'b0);
    io_exec = 1'b1; ir = 16'h0200;
    #1 chk("ski_noskip", skip, 1'b0);
    io_exec = 1'b0;

    // Output transfer, hold, OUT while busy
    ac_low = 8'h3C; io_exec = 1'b1; ir = 16'h0400;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0;
    chk("out_valid", dev_out_valid, 1'b1);
    chk("out_data", dev_out_data, 8'h3C);
    chk("out_fgo", fgo, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("out_hold_data", dev_out_data, 8'h3C);
      chk("out_hold_valid", dev_out_valid, 1'b1);
    end
    io_exec = 1'b1; ir = 16'h0100;
    #1 chk("sko_busy", skip, 1'b0);
    ac_low = 8'h77; ir = 16'h0400;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0;
    chk("out_err_set", out_err, 1'b1);
    chk("out_busy_data", dev_out_data, 8'h3C);
    dev_out_ready = 1'b1;
    @(negedge clk);
    dev_out_ready = 1'b0;
    chk("out_done_valid", dev_out_valid, 1'b0);
    chk("out_done_fgo", fgo, 1'b1);
    chk("out_err_sticky", out_err, 1'b1);
    io_exec = 1'b1; ir = 16'h0100;
    #1 chk("sko_idle", skip, 1'b1);
    io_exec = 1'b0; ir = 16'h0;

    // Interrupts: keep output busy so fgo does not mask the fgi timing
    ac_low = 8'h11; io_exec = 1'b1; ir = 16'h0400;
    @(negedge clk);
    ir = 16'h0080;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0;
    chk("ion_ien", ien, 1'b1);
    chk("ion_irq_quiet", irq, 1'b0);
    dev_in_data = 8'h5A; dev_in_valid = 1'b1;
    @(negedge clk);
    dev_in_valid = 1'b0;
`ifdef IO_RX_FIFO_EN
    @(negedge clk);
`endif
    chk("irq_fgi_rise", fgi, 1'b1);
    chk("irq_lat0", irq, 1'b0);
    @(negedge clk);
    chk("irq_lat1", irq, 1'b1);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    chk("ack_ien", ien, 1'b0);
    chk("ack_irq", irq, 1'b0);
    io_exec = 1'b1; ir = 16'h0080; int_ack = 1'b1;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0; int_ack = 1'b0;
    chk("ack_beats_ion", ien, 1'b0);

    // Reset in the middle of a busy output
    io_exec = 1'b1; ir = 16'h0080;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0;
    chk("pre_rst_ien", ien, 1'b1);
    chk("pre_rst_busy", dev_out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_fgo", fgo, 1'b1);
    chk("arst_valid", dev_out_valid, 1'b0);
    chk("arst_ien", ien, 1'b0);
    chk("arst_inpr", inpr, 8'h00);
    chk("arst_fgi", fgi, 1'b0);
    chk("arst_err", out_err, 1'b0);
    chk("arst_data", dev_out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef IO_RX_FIFO_EN
    for (int b = 1; b <= 5; b++) begin
      dev_in_data = 8'(b); dev_in_valid = 1'b1;
      @(negedge clk);
    end
    dev_in_valid = 1'b0;
    chk("fifo_inpr01", inpr, 8'h01);
    chk("fifo_full_ready", dev_in_ready, 1'b0);
    chk("fifo_fgi", fgi, 1'b1);
    for (int b = 2; b <= 5; b++) begin
      io_exec = 1'b1; ir = 16'h0800;
      @(negedge clk);
      io_exec = 1'b0; ir = 16'h0;
      @(negedge clk);
      chk("fifo_order", inpr, 32'(b));
    end
    chk("fifo_drained_ready", dev_in_ready, 1'b1);
`else
    dev_in_data = 8'hB1; dev_in_valid = 1'b1;
    @(negedge clk);
    dev_in_valid = 1'b0;
    chk("coinc_pre_inpr", inpr, 8'hB1);
    io_exec = 1'b1; ir = 16'h0800; dev_in_data = 8'hC3; dev_in_valid = 1'b1;
    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0;
    chk("coinc_fgi", fgi, 1'b0);
    chk("coinc_no_accept", inpr, 8'hB1);
    chk("coinc_ready", dev_in_ready, 1'b1);
    @(negedge clk);
    dev_in_valid = 1'b0;
    chk("coinc_late_accept", inpr, 8'hC3);
    chk("coinc_late_fgi", fgi, 1'b1);
`endif

    // Random traffic
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fgi_m = 1'b0; out_pend = 1'b0; err_m = 1'b0; ien_m = 1'b0; irq_m = 1'b0;
    in_busy = 1'b0; in_byte = 8'h0; fifo_cnt = 0;
    exp_in.delete(); exp_out.delete();
    sb_on = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
`ifdef IO_RX_FIFO_EN
      ready_m = (fifo_cnt < 4);
`else
      ready_m = !fgi_m;
`endif
      chk("r_fgi", fgi, fgi_m);
      chk("r_fgo", fgo, !out_pend);
      chk("r_valid", dev_out_valid, out_pend);
      chk("r_out_err", out_err, err_m);
      chk("r_ien", ien, ien_m);
      chk("r_irq", irq, irq_m);
      chk("r_in_ready", dev_in_ready, ready_m);

      if (!in_busy && $urandom_range(0, 2) == 0) begin
        in_byte = 8'($urandom);
        in_busy = 1'b1;
        exp_in.push_back(in_byte);
      end
      dev_in_valid  = in_busy;
      dev_in_data   = in_byte;
      dev_out_ready = ($urandom_range(0, 3) == 0);
      io_exec       = ($urandom_range(0, 2) == 0);
      ir            = 16'($urandom);
      if (ir[7] && ir[6]) ir[6] = 1'b0;
      int_ack       = ($urandom_range(0, 15) == 0);
      ac_low        = 8'($urandom);

      inp_c = io_exec & ir[11];
      out_c = io_exec & ir[10];
      ion_c = io_exec & ir[7];
      iof_c = io_exec & ir[6];
      skip_e = io_exec & ((ir[9] & fgi_m) | (ir[8] & !out_pend));
      acc = in_busy & ready_m;
`ifdef IO_RX_FIFO_EN
      pop = !fgi_m && fifo_cnt > 0;
      fgi_n = pop ? 1'b1 : (inp_c ? 1'b0 : fgi_m);
      fifo_cnt = fifo_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
`else
      pop = 1'b0;
      fgi_n = acc ? 1'b1 : (inp_c ? 1'b0 : fgi_m);
`endif
      if (acc) in_busy = 1'b0;
      irq_n = int_ack ? 1'b0 : (ien_m & (fgi_m | !out_pend));
      ien_n = int_ack ? 1'b0 : (iof_c ? 1'b0 : (ion_c ? 1'b1 : ien_m));
      pend_n = out_pend;
      if (out_c) begin
        if (!out_pend) begin
          exp_out.push_back(ac_low);
          pend_n = 1'b1;
        end else begin
          err_m = 1'b1;
        end
      end
      if (out_pend && dev_out_ready) pend_n = 1'b0;

      #1 chk("r_skip", skip, skip_e);
      fgi_m = fgi_n; out_pend = pend_n; ien_m = ien_n; irq_m = irq_n;
    end

    @(negedge clk);
    io_exec = 1'b0; ir = 16'h0; int_ack = 1'b0; dev_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("out_stream_drained", exp_out.size(), 0);
    sb_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
